// File: rtl/mult_rr_arbiter_if.sv
// Handshake bundle between requesters, the shared-multiplier arbiter and the product consumer.
// Requesters and consumer sit on the master side; the arbiter uses the slave modport.
interface mult_rr_arbiter_if #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned INPUT_WIDTH = 16
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ*INPUT_WIDTH-1:0] req_in0;
  logic [NUM_REQ*INPUT_WIDTH-1:0] req_in1;
  logic                           out_valid;
  logic                           out_ready;
  logic [ID_W-1:0]                out_id;
  logic [2*INPUT_WIDTH-1:0]       product;

  modport master (
    output req_valid, req_in0, req_in1, out_ready,
    input  req_ready, out_valid, out_id, product
  );

  modport slave (
    input  req_valid, req_in0, req_in1, out_ready,
    output req_ready, out_valid, out_id, product
  );
endinterface

// File: rtl/mult_rr_arbiter.sv
// Round-robin arbiter feeding one pipelined multiplier; each product leaves LATENCY
// register stages after acceptance, tagged with the requester index.
module mult_rr_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned INPUT_WIDTH = 16,
  parameter bit          IS_SIGNED   = 1'b0,
  parameter int unsigned LATENCY     = 2
) (
  input logic              clk,
  input logic              rst,
  mult_rr_arbiter_if.slave bus
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned PW   = 2 * INPUT_WIDTH;

  logic [ID_W-1:0]        ptr;
  logic [ID_W-1:0]        grant;
  logic [ID_W-1:0]        idx;
  logic                   found;
  logic                   adv;
  logic                   xfer;
  logic [INPUT_WIDTH-1:0] op0;
  logic [INPUT_WIDTH-1:0] op1;
  logic [PW-1:0]          ext0;
  logic [PW-1:0]          ext1;
  logic [PW-1:0]          mul;

  logic                   vld_q  [LATENCY];
  logic [ID_W-1:0]        id_q   [LATENCY];
  logic [PW-1:0]          prod_q [LATENCY];

  // Any output stall freezes the whole pipe and the pointer together.
  assign adv  = !bus.out_valid || bus.out_ready;
  assign xfer = found && adv && !rst;

  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((32'(ptr) + i) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (xfer) bus.req_ready[grant] = 1'b1;
  end

  always_comb begin
    op0 = '0;
    op1 = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        op0 = bus.req_in0[i*INPUT_WIDTH +: INPUT_WIDTH];
        op1 = bus.req_in1[i*INPUT_WIDTH +: INPUT_WIDTH];
      end
    end
  end

  // Extending to the full product width first makes the truncated product exact for both signednesses.
  assign ext0 = IS_SIGNED ? {{INPUT_WIDTH{op0[INPUT_WIDTH-1]}}, op0} : {{INPUT_WIDTH{1'b0}}, op0};
  assign ext1 = IS_SIGNED ? {{INPUT_WIDTH{op1[INPUT_WIDTH-1]}}, op1} : {{INPUT_WIDTH{1'b0}}, op1};
  assign mul  = ext0 * ext1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      for (int unsigned k = 0; k < LATENCY; k++) begin
        vld_q[k]  <= 1'b0;
        id_q[k]   <= '0;
        prod_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q[0]  <= xfer;
      id_q[0]   <= grant;
      prod_q[0] <= mul;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        vld_q[k]  <= vld_q[k-1];
        id_q[k]   <= id_q[k-1];
        prod_q[k] <= prod_q[k-1];
      end
      if (xfer) ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    end
  end

  assign bus.out_valid = vld_q[LATENCY-1];
  assign bus.out_id    = id_q[LATENCY-1];
  assign bus.product   = prod_q[LATENCY-1];
endmodule
